gcd_unit: RTL

//   Iterative Euclid GCD engine: accepts one {A,B} operand pair per request
//   and returns gcd(A,B) as a single response. Sits directly upstream of the
//   GCD response sink and downstream of the request source. Both sides use
//   val/rdy handshakes. One transaction is in flight at a time.
//

---
 rtl/gcd_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/gcd_unit.sv
// -----------------------------------------------------------------------------
// gcd_unit
//   Iterative Euclid GCD engine. Accepts one {A,B} operand pair per request
//   over a val/rdy handshake, computes gcd(A,B) by repeated swap/subtract,
//   and returns the result as one response over a second val/rdy handshake.
//   Only one transaction is in flight at a time.
//
// Parameters
//   W         operand/result width (req_msg is 2*W bits)
//
// Ports
//   clk       in   1    clock, all state updates on rising edge
//   reset     in   1    asynchronous, active-high reset
//   req_val   in   1    request valid
//   req_rdy   out  1    request ready, high only while idle
//   req_msg   in   2*W  {A, B}, unsigned, A in the upper half
//   resp_val  out  1    response valid, high only while a result is held
//   resp_rdy  in   1    response ready from downstream
//   resp_msg  out  W    gcd(A,B); mirrors the A register in every state
// -----------------------------------------------------------------------------
module gcd_unit #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_val,
  output logic           req_rdy,
  input  logic [2*W-1:0] req_msg,
  output logic           resp_val,
  input  logic           resp_rdy,
  output logic [W-1:0]   resp_msg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_r;
  state_t       state_s;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic         rdy_r;
  logic         val_r;

  // Next-state and datapath selection; one Euclid step per CALC cycle.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    case (state_r)
      IDLE: begin
        if (req_val && rdy_r) begin
          a_s     = req_msg[2*W-1:W];
          b_s     = req_msg[W-1:0];
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (a_r < b_r) begin
          // Keep A >= B so the subtract below can never underflow.
          a_s = b_r;
          b_s = a_r;
        end else if (b_r != {W{1'b0}}) begin
          a_s = a_r - b_r;
        end else begin
          // B reached zero: A now holds the result.
          state_s = DONE;
        end
      end
      DONE: begin
        if (val_r && resp_rdy) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
    end
  end

  // Handshake flags registered from the next state, so neither ready nor
  // valid has any combinational path from the opposite-side inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_r <= 1'b1;
      val_r <= 1'b0;
    end else begin
      rdy_r <= (state_s == IDLE);
      val_r <= (state_s == DONE);
    end
  end

  assign req_rdy  = rdy_r;
  assign resp_val = val_r;
  assign resp_msg = a_r;

endmodule
